// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: float32 samples are converted to saturated 24-bit PCM, buffered in a
// small FIFO and sent as a mono I2S stream, with the same word in the left and right slots.
module i2s_dac_tx #(
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic        sample_valid,
  input  logic [31:0] sample_in,
  input  logic        clear_flags,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        fifo_full,
  output logic        overflow,
  output logic        underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_TC  = DW'(BCLK_DIV - 1);

  logic          conv_valid_q, conv_valid_d;
  logic [23:0]   conv_word_q, conv_word_d;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [23:0]   word_q, word_d;
  logic          bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
  logic          full_q, full_d, ovf_q, ovf_d, und_q, und_d;

  logic [7:0]  exp_f;
  logic [23:0] mant, mag;
  logic [4:0]  slot_t;
  logic        fall_evt, frame_start, pop, wr_en, fifo_at_depth;

  // Float -> 24-bit PCM: trunc(|v| * 2^23) = m >> (127 - e) for 104 <= e <= 126.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    exp_f       = sample_in[30:23];
    mant        = {1'b1, sample_in[22:0]};
    mag         = mant >> 5'(8'd127 - exp_f);
    conv_word_d = '0;
    if (exp_f == 8'hFF && sample_in[22:0] != 23'd0) begin
      conv_word_d = '0;
    end else if (exp_f >= 8'd127) begin
      conv_word_d = sample_in[31] ? 24'h800000 : 24'h7FFFFF;
    end else if (exp_f >= 8'd104) begin
      conv_word_d = sample_in[31] ? (24'd0 - mag) : mag;
    end
    conv_valid_d = sample_valid;
  end

  always_comb begin
    fifo_at_depth = (count_q == DEPTH_C);
    fall_evt      = (div_cnt_q == DIV_TC) && bclk_q;
    frame_start   = fall_evt && (bit_cnt_q == 6'd63);
    pop           = frame_start && (count_q != '0);
    wr_en         = conv_valid_q && (!fifo_at_depth || pop);

    wr_ptr_d  = wr_ptr_q + AW'(wr_en);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    full_d    = (count_d == DEPTH_C);

    div_cnt_d = (div_cnt_q == DIV_TC) ? '0 : div_cnt_q + DW'(1);
    bclk_d    = (div_cnt_q == DIV_TC) ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    word_d    = word_q;
    slot_t    = 5'(bit_cnt_q + 6'd1);

    if (frame_start) begin
      word_d = pop ? mem[rd_ptr_q] : '0;
    end
    if (fall_evt) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrck_d    = bit_cnt_d[5];
      // Slot bit 0 is the I2S one-bit delay; bits 1..24 carry the word MSB first.
      sdata_d   = (slot_t >= 5'd1 && slot_t <= 5'd24) ? word_q[5'(5'd24 - slot_t)] : 1'b0;
    end

    ovf_d = (conv_valid_q && fifo_at_depth && !pop) || (ovf_q && !clear_flags);
    und_d = (frame_start && count_q == '0) || (und_q && !clear_flags);
  end

  // NOTE: sample storage is never reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= conv_word_q;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!aclr_n) begin
      conv_valid_q <= 1'b0;
      conv_word_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= 6'd63;
      word_q       <= '0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      sdata_q      <= 1'b0;
      full_q       <= 1'b0;
      ovf_q        <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      conv_valid_q <= conv_valid_d;
      conv_word_q  <= conv_word_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      bclk_q       <= bclk_d;
      lrck_q       <= lrck_d;
      sdata_q      <= sdata_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      und_q        <= und_d;
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;
  assign fifo_full = full_q;
  assign overflow  = ovf_q;
  assign underrun  = und_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: a bit-level I2S receiver model rebuilds each frame and compares the
// left/right words against a queue of expected PCM words pushed as samples are driven.
module tb_i2s_dac_tx;

  localparam int BCLK_DIV = 4;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic        sample_valid;
  logic [31:0] sample_in;
  logic        clear_flags;
  logic        i2s_bclk, i2s_lrck, i2s_sdata, fifo_full, overflow, underrun;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] f;
    logic [23:0] w;
  } vec_t;

  vec_t vecs [14];
  logic [23:0] sb_q [$];

  // Receiver model state
  int          pos = 63;
  bit          prev_bclk = 1'b0;
  bit          frame_valid = 1'b0;
  logic [23:0] left_w, right_w, exp_w;
  int          frame_errs;
  int          frame_cnt = 0;
  int          fall63_cnt = 0;

  i2s_dac_tx #(.BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .aclr_n       (aclr_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .clear_flags  (clear_flags),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame position advances on each BCLK fall; data is taken on the following BCLK rise.
  always @(negedge clk) begin
    if (!aclr_n) begin
      pos         = 63;
      prev_bclk   = 1'b0;
      frame_valid = 1'b0;
    end else begin
      if (prev_bclk && !i2s_bclk) begin
        pos = (pos + 1) % 64;
        if (pos == 63) fall63_cnt++;
        if (pos == 0) begin
          frame_cnt++;
          exp_w       = (sb_q.size() != 0) ? sb_q.pop_front() : 24'h000000;
          left_w      = '0;
          right_w     = '0;
          frame_errs  = 0;
          frame_valid = 1'b1;
        end
      end
      if (!prev_bclk && i2s_bclk && frame_valid) begin
        if (i2s_lrck !== pos[5]) frame_errs++;
        if (pos[4:0] >= 1 && pos[4:0] <= 24) begin
          if (pos[5]) right_w[24 - pos[4:0]] = i2s_sdata;
          else        left_w[24 - pos[4:0]]  = i2s_sdata;
        end else if (i2s_sdata !== 1'b0) begin
          frame_errs++;
        end
        if (pos == 63) begin
          check("frame_left", left_w, exp_w);
          check("frame_right", right_w, exp_w);
          check("frame_format", frame_errs, 0);
        end
      end
      prev_bclk = i2s_bclk;
    end
  end

  task automatic send(input logic [31:0] f, input logic [23:0] w, input bit drop);
    sample_in    = f;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    if (!drop) sb_q.push_back(w);
  endtask

  // Returns 1 ns after the clock edge that follows the next frame-start fall.
  task automatic wait_frame_start();
    int start = frame_cnt;
    bit seen  = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      if (frame_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    check("frame_start_seen", 32'(seen), 1);
  endtask

  // Returns 1 ns after the edge lying n clocks before the next frame-start edge.
  task automatic wait_before_fs(input int n);
    int start = fall63_cnt;
    bit seen  = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk);
      if (fall63_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (2*BCLK_DIV - n - 1) @(posedge clk);
    #1;
    check("pre_frame_start_seen", 32'(seen), 1);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
  endtask

  task automatic release_check();
    int  n = 0;
    bit  saw_high = 1'b0;
    aclr_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i2s_bclk) saw_high = 1'b1;
      else if (saw_high) begin
        n = i;
        break;
      end
    end
    check("first_fall_clks", n, 2*BCLK_DIV);
    check("first_fall_lrck", 32'(i2s_lrck), 0);
    check("first_fall_underrun", 32'(underrun), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h3F000000, 24'h400000};
    vecs[1]  = '{32'hBF800000, 24'h800000};
    vecs[2]  = '{32'h40000000, 24'h7FFFFF};
    vecs[3]  = '{32'h7FC00000, 24'h000000};
    vecs[4]  = '{32'h3A800000, 24'h002000};
    vecs[5]  = '{32'hBF000000, 24'hC00000};
    vecs[6]  = '{32'h7F800000, 24'h7FFFFF};
    vecs[7]  = '{32'hFF800000, 24'h800000};
    vecs[8]  = '{32'h00000001, 24'h000000};
    vecs[9]  = '{32'h33800000, 24'h000000};
    vecs[10] = '{32'h34000000, 24'h000001};
    vecs[11] = '{32'h3F7FFFFF, 24'h7FFFFF};
    vecs[12] = '{32'hBEAAAAAB, 24'hD55556};
    vecs[13] = '{32'h80000000, 24'h000000};

    aclr_n       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    clear_flags  = 1'b0;
    #1;
    check("reset_outputs",
          {26'd0, i2s_bclk, i2s_lrck, i2s_sdata, fifo_full, overflow, underrun}, 0);
    repeat (3) @(posedge clk);
    #1;

    // Empty first frame, then clear and re-set of the sticky underrun.
    release_check();
    repeat (50) @(posedge clk);
    #1;
    pulse_clear();
    check("underrun_cleared", 32'(underrun), 0);
    wait_frame_start();
    check("underrun_reset_again", 32'(underrun), 1);
    wait_before_fs(1);
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    check("underrun_set_beats_clear", 32'(underrun), 1);

    // Conversion table: one sample per frame, emitted in the frame after it is sent.
    for (int i = 0; i < 14; i++) begin
      wait_frame_start();
      send(vecs[i].f, vecs[i].w, 1'b0);
    end

    // Fill to depth, then one more sample is dropped.
    wait_frame_start();
    send(32'h3F000000, 24'h400000, 1'b0);
    @(posedge clk); #1; check("full_after_1", 32'(fifo_full), 0); repeat (2) @(posedge clk); #1;
    send(32'h3E800000, 24'h200000, 1'b0);
    @(posedge clk); #1; check("full_after_2", 32'(fifo_full), 0); repeat (2) @(posedge clk); #1;
    send(32'h3E000000, 24'h100000, 1'b0);
    @(posedge clk); #1; check("full_after_3", 32'(fifo_full), 0); repeat (2) @(posedge clk); #1;
    send(32'hBF000000, 24'hC00000, 1'b0);
    @(posedge clk); #1; check("full_after_4", 32'(fifo_full), 1);
    check("no_overflow_at_4", 32'(overflow), 0);
    repeat (2) @(posedge clk); #1;
    send(32'h3F400000, 24'h600000, 1'b1);
    @(posedge clk); #1;
    check("overflow_after_5", 32'(overflow), 1);
    check("full_after_5", 32'(fifo_full), 1);
    pulse_clear();
    check("overflow_cleared", 32'(overflow), 0);

    // Refill to depth, then write on the same edge as the frame-start pop.
    wait_frame_start();
    check("full_after_pop", 32'(fifo_full), 0);
    send(32'h3D800000, 24'h080000, 1'b0);
    @(posedge clk); #1;
    check("full_refilled", 32'(fifo_full), 1);
    wait_before_fs(2);
    send(32'hBE800000, 24'hE00000, 1'b0);
    @(posedge clk); #1;
    check("coincident_no_overflow", 32'(overflow), 0);
    check("coincident_full", 32'(fifo_full), 1);
    check("coincident_no_underrun", 32'(underrun), 0);
    repeat (2) @(posedge clk); #1;
    check("coincident_full_hold", 32'(fifo_full), 1);
    repeat (5) wait_frame_start();
    check("drained_underrun", 32'(underrun), 1);
    check("drained_not_full", 32'(fifo_full), 0);

    // Reset in the middle of the right slot with a full FIFO.
    wait_frame_start();
    for (int i = 0; i < 4; i++) send(32'h3F000000, 24'h400000, 1'b0);
    @(posedge clk); #1;
    check("prereset_full", 32'(fifo_full), 1);
    repeat (300) @(posedge clk);
    #1;
    check("prereset_right_slot", 32'(i2s_lrck), 1);
    #3;
    aclr_n = 1'b0;
    #1;
    check("midframe_reset_outputs",
          {26'd0, i2s_bclk, i2s_lrck, i2s_sdata, fifo_full, overflow, underrun}, 0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    release_check();
    repeat (2) wait_frame_start();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
